// File: rtl/unary_stream_gen.sv
`timescale 1ns/1ps
// unary_stream_gen: feeder for the unary adder stage.
// Takes two binary operands through a valid/ready handshake and plays them
// out as thermometer-coded serial streams (ones first), then holds the adder
// in write mode for a drain window and pulses done.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for an operand pair, in_ready high
// S_STREAM | LEN cycles of read phase, bit k of each unary stream driven
// S_WRITE  | DRAIN cycles of write phase, adder emits its sum
// S_DONE   | one-cycle done pulse, then back to idle
//
// Every output is a register loaded from the decoded next state, so the
// outputs of a cycle always describe the state the FSM is in that cycle.
module unary_stream_gen #(
    parameter int LEN   = 16,
    parameter int W     = 5,
    parameter int DRAIN = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a_val,
    input  logic [W-1:0] b_val,
    input  logic         abort,
    output logic         A,
    output logic         B,
    output logic         en,
    output logic         read_or_write,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int KW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int DW = $clog2(DRAIN + 1);

    localparam logic [W-1:0]  LEN_V  = W'(LEN);
    localparam logic [KW-1:0] K_LAST = KW'(LEN - 1);
    localparam logic [DW-1:0] D_LOAD = DW'(DRAIN - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t        state, nxt_state;
    logic [KW-1:0] k, nxt_k;
    logic [DW-1:0] dcnt, nxt_dcnt;
    logic [W-1:0]  a_q, b_q, nxt_a_q, nxt_b_q;
    logic          nxt_err;
    logic          accept;

    logic          nxt_in_ready, nxt_busy, nxt_en, nxt_rw, nxt_done;
    logic          nxt_a_bit, nxt_b_bit;

    // An abort seen in idle suppresses a simultaneous accept.
    assign accept = (state == S_IDLE) && in_valid && !abort;

    // State register together with the counters, operand latches and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            k             <= '0;
            dcnt          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            err           <= 1'b0;
            in_ready      <= 1'b1;
            busy          <= 1'b0;
            en            <= 1'b0;
            read_or_write <= 1'b0;
            A             <= 1'b0;
            B             <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= nxt_state;
            k             <= nxt_k;
            dcnt          <= nxt_dcnt;
            a_q           <= nxt_a_q;
            b_q           <= nxt_b_q;
            err           <= nxt_err;
            in_ready      <= nxt_in_ready;
            busy          <= nxt_busy;
            en            <= nxt_en;
            read_or_write <= nxt_rw;
            A             <= nxt_a_bit;
            B             <= nxt_b_bit;
            done          <= nxt_done;
        end
    end

    // Next-state logic: handshake, clamping, bit index and drain down-counter.
    always_comb begin
        nxt_state = state;
        nxt_k     = k;
        nxt_dcnt  = dcnt;
        nxt_a_q   = a_q;
        nxt_b_q   = b_q;
        nxt_err   = err;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    nxt_a_q   = (a_val > LEN_V) ? LEN_V : a_val;
                    nxt_b_q   = (b_val > LEN_V) ? LEN_V : b_val;
                    nxt_err   = (a_val > LEN_V) || (b_val > LEN_V);
                    nxt_k     = '0;
                    nxt_state = S_STREAM;
                end
            end
            S_STREAM: begin
                if (abort) begin
                    nxt_state = S_IDLE;
                end else if (k == K_LAST) begin
                    nxt_dcnt  = D_LOAD;
                    nxt_state = S_WRITE;
                end else begin
                    nxt_k = k + KW'(1);
                end
            end
            S_WRITE: begin
                if (abort) begin
                    nxt_state = S_IDLE;
                end else if (dcnt == '0) begin
                    nxt_state = S_DONE;
                end else begin
                    nxt_dcnt = dcnt - DW'(1);
                end
            end
            S_DONE: begin
                nxt_state = S_IDLE;
            end
            default: begin
                nxt_state = S_IDLE;
            end
        endcase
    end

    // Output decode of the next state, registered in the state register block.
    always_comb begin
        nxt_in_ready = (nxt_state == S_IDLE);
        nxt_busy     = (nxt_state != S_IDLE);
        nxt_en       = (nxt_state == S_STREAM) || (nxt_state == S_WRITE);
        nxt_rw       = (nxt_state == S_WRITE);
        nxt_done     = (nxt_state == S_DONE);
        nxt_a_bit    = 1'b0;
        nxt_b_bit    = 1'b0;
        if (nxt_state == S_STREAM) begin
            nxt_a_bit = (W'(nxt_k) < nxt_a_q);
            nxt_b_bit = (W'(nxt_k) < nxt_b_q);
        end
    end

endmodule

// File: tb/tb_unary_stream_gen.sv
`timescale 1ns/1ps
// Directed bench for unary_stream_gen with LEN=16, DRAIN=33.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_unary_stream_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] a_val;
    logic [4:0] b_val;
    logic       abort;
    logic       A, B, en, read_or_write, busy, done, err;

    int n_assert = 0;
    int n_fail   = 0;

    // Packed view {in_ready, busy, en, read_or_write, A, B, done}.
    localparam logic [6:0] V_IDLE  = 7'b1000000;
    localparam logic [6:0] V_WRITE = 7'b0111000;
    localparam logic [6:0] V_DONE  = 7'b0100001;

    always #5 clk = ~clk;

    unary_stream_gen #(.LEN(16), .W(5), .DRAIN(33)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a_val        (a_val),
        .b_val        (b_val),
        .abort        (abort),
        .A            (A),
        .B            (B),
        .en           (en),
        .read_or_write(read_or_write),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    function automatic logic [6:0] outs();
        return {in_ready, busy, en, read_or_write, A, B, done};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One full transaction from the accept edge through the idle cycle after done.
    // With hold set, in_valid stays high and the operands switch to a2/b2.
    task automatic run_txn(input string name, input logic [4:0] a, input logic [4:0] b,
                           input logic [15:0] ea, input logic [15:0] eb, input logic eerr,
                           input bit hold, input logic [4:0] a2, input logic [4:0] b2);
        a_val    = a;
        b_val    = b;
        in_valid = 1'b1;
        @(negedge clk);
        if (hold) begin
            a_val = a2;
            b_val = b2;
        end else begin
            in_valid = 1'b0;
        end
        check({name, "_err_accept"}, {7'd0, err}, {7'd0, eerr});
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s_stream%0d", name, i), {1'b0, outs()},
                  {1'b0, 4'b0110, ea[15-i], eb[15-i], 1'b0});
            @(negedge clk);
        end
        for (int i = 0; i < 33; i++) begin
            check($sformatf("%s_write%0d", name, i), {1'b0, outs()}, {1'b0, V_WRITE});
            @(negedge clk);
        end
        check({name, "_done"}, {1'b0, outs()}, {1'b0, V_DONE});
        @(negedge clk);
        check({name, "_idle"}, {1'b0, outs()}, {1'b0, V_IDLE});
        check({name, "_err_end"}, {7'd0, err}, {7'd0, eerr});
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        abort    = 1'b0;
        a_val    = '0;
        b_val    = '0;

        @(negedge clk);
        check("reset_outs", {1'b0, outs()}, {1'b0, V_IDLE});
        check("reset_err", {7'd0, err}, 8'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_idle", {1'b0, outs()}, {1'b0, V_IDLE});

        run_txn("a3b12", 5'd3, 5'd12, 16'hE000, 16'hFFF0, 1'b0, 1'b0, 5'd0, 5'd0);
        run_txn("a0b16", 5'd0, 5'd16, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 5'd0, 5'd0);
        run_txn("a20b5", 5'd20, 5'd5, 16'hFFFF, 16'hF800, 1'b1, 1'b0, 5'd0, 5'd0);
        run_txn("a1b1",  5'd1, 5'd1, 16'h8000, 16'h8000, 1'b0, 1'b0, 5'd0, 5'd0);

        // Operands change under a held in_valid; the second pair waits for idle.
        run_txn("hold", 5'd2, 5'd4, 16'hC000, 16'hF000, 1'b0, 1'b1, 5'd7, 5'd9);
        @(negedge clk);
        check("hold_second_accept", {1'b0, outs()}, {1'b0, 7'b0110110});
        check("hold_second_err", {7'd0, err}, 8'd0);
        in_valid = 1'b0;
        abort    = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_stream_idle", {1'b0, outs()}, {1'b0, V_IDLE});

        // Abort in the fifth write cycle: straight to idle, no done, err kept.
        a_val    = 5'd20;
        b_val    = 5'd0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("abw_err_set", {7'd0, err}, 8'd1);
        repeat (20) @(negedge clk);
        check("abw_write5", {1'b0, outs()}, {1'b0, V_WRITE});
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abw_idle", {1'b0, outs()}, {1'b0, V_IDLE});
        check("abw_err_kept", {7'd0, err}, 8'd1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check($sformatf("abw_no_done%0d", i), {1'b0, outs()}, {1'b0, V_IDLE});
        end

        // Reset mid-stream overrides abort and in_valid, and clears err.
        a_val    = 5'd5;
        b_val    = 5'd5;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pre_stream3", {1'b0, outs()}, {1'b0, 7'b0110110});
        rst      = 1'b1;
        abort    = 1'b1;
        in_valid = 1'b1;
        a_val    = 5'd3;
        @(negedge clk);
        check("rst_mid_outs", {1'b0, outs()}, {1'b0, V_IDLE});
        check("rst_mid_err", {7'd0, err}, 8'd0);
        rst      = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_no_accept", {1'b0, outs()}, {1'b0, V_IDLE});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/unary_stream_gen.md
# unary_stream_gen

Upstream feeder for the unary adder stage. It accepts two binary operands through a valid/ready handshake and converts each into a thermometer-coded serial unary stream (ones first, then zeros) on `A` and `B`, one bit per clock. It drives the adder's `en` and `read_or_write` controls through a read phase and then a write/drain phase, and pulses `done` when the adder's output window has elapsed. The block is the sole driver of the adder's `A`, `B`, `en` and `read_or_write` inputs.

## Interface
- `LEN`, default 16: stream length in bits; maximum representable operand value.
- `W`, default 5: operand width; must satisfy 2^W > LEN.
- `DRAIN`, default 33: number of write-phase cycles; must be ≥ 2*LEN+1 so the full sum can be emitted.
- `clk` input, 1 bit: single clock; all logic is rising-edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `in_valid` input, 1 bit: operand pair is valid.
- `in_ready` output, 1 bit: block can accept an operand pair; high only in IDLE.
- `a_val` input, W bits: operand A, unsigned binary.
- `b_val` input, W bits: operand B, unsigned binary.
- `abort` input, 1 bit: synchronous cancel of the current transaction.
- `A` output, 1 bit: unary stream for operand A, to the adder.
- `B` output, 1 bit: unary stream for operand B, to the adder.
- `en` output, 1 bit: adder enable.
- `read_or_write` output, 1 bit: 0 = adder read (accumulate), 1 = adder write (emit).
- `busy` output, 1 bit: a transaction is in progress (any state other than IDLE).
- `done` output, 1 bit: one-cycle pulse at the end of the write phase.
- `err` output, 1 bit: sticky flag; the last accepted operand exceeded LEN and was clamped.

## Operation
- All outputs are registered.
- FSM states: IDLE, STREAM, WRITE, DONE.
- **IDLE**
  - `in_ready`=1; all other outputs 0, except `err`, which holds its value.
  - When `in_valid && in_ready`: latch `a_q = min(a_val, LEN)` and `b_q = min(b_val, LEN)`.
  - Set `err` = (`a_val` > LEN) || (`b_val` > LEN).
  - Clear the bit index `k` to 0 and go to STREAM.
- **STREAM** (exactly LEN cycles, k = 0..LEN-1)
  - `en`=1, `read_or_write`=0, `A` = (k < a_q), `B` = (k < b_q).
  - After k = LEN-1, go to WRITE.
- **WRITE** (exactly DRAIN cycles)
  - `en`=1, `read_or_write`=1, `A`=0, `B`=0.
  - After the last cycle, go to DONE.
- **DONE** (1 cycle)
  - `done`=1, `en`=0, `read_or_write`=0, `busy`=1.
  - Go to IDLE.
- `in_valid` is ignored outside IDLE; latched operands are never overwritten mid-transaction.
- Counters: the STREAM index is ceil(log2(LEN)) bits. The WRITE counter is wide enough for DRAIN. Neither counter wraps, because each state exits on its terminal count.
- `abort` in STREAM, WRITE or DONE: at the next edge go to IDLE; `en`, `A`, `B`, `read_or_write` and `done` become 0; no `done` pulse is issued; `err` is unchanged. `abort` in IDLE has no effect, and it takes priority over an accept in the same cycle.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `A`=`B`=`en`=`read_or_write`=`busy`=`done`=`err`=0, all counters and latched operands 0.
- `rst` asserted in any state forces these values at the next edge and overrides `abort` and `in_valid`.
- Accept at edge T. STREAM occupies cycles T+1 .. T+LEN; `A` bit k appears in cycle T+1+k.
- WRITE occupies cycles T+LEN+1 .. T+LEN+DRAIN.
- `done` is high in cycle T+LEN+DRAIN+1.
- `in_ready` returns high in cycle T+LEN+DRAIN+2. The earliest next accept is at the end of that cycle, so there is no back-to-back overlap.
- `busy` is high in cycles T+1 through T+LEN+DRAIN+1 inclusive.
- Boundary cases:
  - a=0: `A` is 0 for all STREAM cycles.
  - a=LEN: `A` is 1 for all STREAM cycles.
  - a>LEN: `A` is 1 for all STREAM cycles and `err`=1.
  - `err` clears only on the next accept with both operands in range, or on reset.

## Test plan
- Reset, then LEN=16, DRAIN=33, a=3, b=12 → `A` = 1110000000000000 and `B` = 1111111111110000 over STREAM; `en`=1 for 49 cycles; `read_or_write` rises after 16 cycles; `done` pulses 50 cycles after accept; `err`=0.
- a=0, b=16 → `A` all 0 and `B` all 1 for 16 cycles; `done` is at the same cycle offset as above.
- a=20, b=5 → `A` all 1 (clamped), `err`=1 after accept; the next transaction with a=1, b=1 clears `err`.
- `in_valid` held high with changing `a_val` during STREAM → `in_ready`=0 and the streams reflect only the first operand pair; the second pair is accepted one cycle after `done`.
- `abort` in WRITE cycle 5 → next cycle IDLE with `en`=0, `read_or_write`=0, no `done` pulse, and `in_ready`=1.
- `rst` asserted mid-STREAM with `abort` and `in_valid` also high → all outputs at reset values at the next edge and no accept in that cycle.
